// File: rtl/vga_scanout.sv
// vga_scanout: read side of the 160x120 3-bit framebuffer.
// Generates 640x480@60 VGA timing from a 50 MHz clock (25 MHz pixel tick),
// fetches one framebuffer pixel per 4x4 screen block and drives the DAC pins.
// Pins lag the raster counters by two pixel ticks; sync and colour stay aligned.
module vga_scanout #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int ADDR_W    = 15
) (
    input  logic              clock,
    input  logic              reset,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [2:0]        rd_data,
    output logic [3:0]        VGA_R,
    output logic [3:0]        VGA_G,
    output logic [3:0]        VGA_B,
    output logic              VGA_HS,
    output logic              VGA_VS,
    output logic              VGA_BLANK,
    output logic              frame_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int H_W     = $clog2(H_TOTAL);
    localparam int V_W     = $clog2(V_TOTAL);

    localparam logic [H_W-1:0] H_LAST   = H_W'(H_TOTAL - 1);
    localparam logic [H_W-1:0] H_VIS    = H_W'(H_VISIBLE);
    localparam logic [H_W-1:0] HS_FIRST = H_W'(H_VISIBLE + H_FRONT);
    localparam logic [H_W-1:0] HS_LAST  = H_W'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [V_W-1:0] V_LAST   = V_W'(V_TOTAL - 1);
    localparam logic [V_W-1:0] V_VIS    = V_W'(V_VISIBLE);
    localparam logic [V_W-1:0] VS_FIRST = V_W'(V_VISIBLE + V_FRONT);
    localparam logic [V_W-1:0] VS_LAST  = V_W'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    logic              pix_en;
    logic [H_W-1:0]    h_cnt;
    logic [V_W-1:0]    v_cnt;

    logic              vis;
    logic              hs_n;
    logic              vs_n;
    logic [ADDR_W-1:0] fb_x;
    logic [ADDR_W-1:0] fb_y;
    logic [ADDR_W-1:0] addr_next;

    logic              vis_d1;
    logic              hs_d1;
    logic              vs_d1;

    // Pixel tick: high on alternate clocks, first high on the second edge after reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pix_en <= 1'b0;
        end else begin
            pix_en <= ~pix_en;
        end
    end

    // Raster counters: h wraps at H_TOTAL-1 and carries into v, which wraps at V_TOTAL-1.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pix_en) begin
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                if (v_cnt == V_LAST) begin
                    v_cnt <= '0;
                end else begin
                    v_cnt <= v_cnt + 1'b1;
                end
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
        end
    end

    // Stage 0 decode: visibility, sync windows and the y*160+x address (shift-add, no multiplier).
    always_comb begin
        vis       = (h_cnt < H_VIS) && (v_cnt < V_VIS);
        hs_n      = !((h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST));
        vs_n      = !((v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST));
        fb_x      = ADDR_W'(h_cnt >> 2);
        fb_y      = ADDR_W'(v_cnt >> 2);
        addr_next = (fb_y << 7) + (fb_y << 5) + fb_x;
    end

    // Stage 1: issue the RAM read (held during blanking) and delay the decoded controls.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_addr <= '0;
            vis_d1  <= 1'b0;
            hs_d1   <= 1'b1;
            vs_d1   <= 1'b1;
        end else if (pix_en) begin
            vis_d1 <= vis;
            hs_d1  <= hs_n;
            vs_d1  <= vs_n;
            if (vis) begin
                rd_addr <= addr_next;
            end
        end
    end

    // Stage 2: capture RAM data one tick later, replicate each bit to 4, force black in blanking.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            VGA_R     <= '0;
            VGA_G     <= '0;
            VGA_B     <= '0;
            VGA_HS    <= 1'b1;
            VGA_VS    <= 1'b1;
            VGA_BLANK <= 1'b0;
        end else if (pix_en) begin
            VGA_R     <= vis_d1 ? {4{rd_data[2]}} : '0;
            VGA_G     <= vis_d1 ? {4{rd_data[1]}} : '0;
            VGA_B     <= vis_d1 ? {4{rd_data[0]}} : '0;
            VGA_HS    <= hs_d1;
            VGA_VS    <= vs_d1;
            VGA_BLANK <= vis_d1;
        end
    end

    // Start-of-vblank marker, taken straight from the counters on the advancing clock.
    always_comb begin
        frame_start = pix_en && (h_cnt == '0) && (v_cnt == V_VIS);
    end

endmodule

// File: tb/tb_vga_scanout.sv
// tb_vga_scanout: randomized framebuffer contents checked against a raster
// model computed from clock counts since reset release. The vertical timing is
// shortened so whole frames fit in a short run; horizontal timing is standard.
module tb_vga_scanout;

    localparam int HV = 640, HF = 16, HS = 96, HB = 48;
    localparam int VV = 8, VF = 1, VSY = 2, VB = 1;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VSY + VB;
    localparam int FRAME = HT * VT;
    localparam int FB = 19200;
    localparam logic [15:0] RESET_PINS = 16'h000C;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [14:0] rd_addr;
    logic [2:0]  rd_data = 3'b000;
    logic [3:0]  VGA_R, VGA_G, VGA_B;
    logic        VGA_HS, VGA_VS, VGA_BLANK, frame_start;

    logic [2:0]  mem [0:FB-1];
    int unsigned t = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    vga_scanout #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSY), .V_BACK(VB),
        .ADDR_W(15)
    ) dut (
        .clock(clock), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data),
        .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
        .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_BLANK(VGA_BLANK),
        .frame_start(frame_start)
    );

    always #10 clock = ~clock;

    // clock edges since reset release
    always @(posedge clock) begin
        if (reset) t <= 0;
        else       t <= t + 1;
    end

    // synchronous framebuffer RAM, one clock read latency
    always @(posedge clock) begin
        rd_data <= (int'(rd_addr) < FB) ? mem[rd_addr] : 3'b000;
    end

    // Expected {R,G,B,HS,VS,BLANK,frame_start} after edge tt.
    // Pixel ticks land on even edges; the pins show the raster position of two ticks earlier.
    function automatic logic [15:0] pins_model(input int unsigned tt);
        int unsigned k, q, h, v;
        logic [2:0] d;
        logic vis, hs, vs, fs;
        logic [3:0] r, g, b;
        r = 4'h0; g = 4'h0; b = 4'h0; hs = 1'b1; vs = 1'b1; vis = 1'b0; fs = 1'b0;
        k = tt / 2;
        if (k >= 2) begin
            q = (k - 2) % FRAME;
            h = q % HT;
            v = q / HT;
            vis = (h < HV) && (v < VV);
            hs = !((h >= HV + HF) && (h < HV + HF + HS));
            vs = !((v >= VV + VF) && (v < VV + VF + VSY));
            if (vis) begin
                d = mem[(v / 4) * 160 + h / 4];
                r = d[2] ? 4'hF : 4'h0;
                g = d[1] ? 4'hF : 4'h0;
                b = d[0] ? 4'hF : 4'h0;
            end
        end
        if (tt % 2 == 1) fs = ((((tt - 1) / 2) % FRAME) == VV * HT);
        return {r, g, b, hs, vs, vis, fs};
    endfunction

    // Expected read address after edge tt, or -1 when the address is merely being held.
    function automatic int addr_model(input int unsigned tt);
        int unsigned k, q, h, v;
        k = tt / 2;
        if (k >= 1) begin
            q = (k - 1) % FRAME;
            h = q % HT;
            v = q / HT;
            if ((h < HV) && (v < VV)) return int'((v / 4) * 160 + h / 4);
        end
        return -1;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [15:0] act;
        #2 reset = 1'b1;
        #1;
        act = {VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_BLANK, frame_start};
        n_cmp++;
        if (act !== RESET_PINS) begin n_bad++; $display("FAIL reset_async_pins got %h expected %h", act, RESET_PINS); end
        repeat (2) @(posedge clock);
        #1;
        act = {VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_BLANK, frame_start};
        n_cmp++;
        if (act !== RESET_PINS) begin n_bad++; $display("FAIL reset_held_pins got %h expected %h", act, RESET_PINS); end
        n_cmp++;
        if (rd_addr !== 15'd0) begin n_bad++; $display("FAIL reset_rd_addr got %0d expected 0", rd_addr); end
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_hsync();
        int unsigned falls[$];
        int unsigned rises[$];
        logic prev;
        logic [15:0] act, exp;
        prev = VGA_HS;
        repeat (5000) begin
            @(posedge clock); #1;
            exp = pins_model(t);
            act = {VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_BLANK, frame_start};
            n_cmp++;
            if (act !== exp) begin n_bad++; $display("FAIL hsync_pins t=%0d got %h expected %h", t, act, exp); end
            if (prev === 1'b1 && VGA_HS === 1'b0) falls.push_back(t);
            if (prev === 1'b0 && VGA_HS === 1'b1) rises.push_back(t);
            prev = VGA_HS;
        end
        n_cmp++;
        if (falls.size() != 3 || rises.size() < 1) begin
            n_bad++; $display("FAIL hsync_edge_count got falls=%0d rises=%0d expected falls=3 rises>=1", falls.size(), rises.size());
        end else begin
            n_cmp++;
            if (falls[0] != 1316) begin n_bad++; $display("FAIL hsync_first_fall got %0d expected 1316", falls[0]); end
            n_cmp++;
            if (falls[1] - falls[0] != 1600) begin n_bad++; $display("FAIL hsync_period got %0d expected 1600", falls[1] - falls[0]); end
            n_cmp++;
            if (falls[2] - falls[1] != 1600) begin n_bad++; $display("FAIL hsync_period2 got %0d expected 1600", falls[2] - falls[1]); end
            n_cmp++;
            if (rises[0] - falls[0] != 192) begin n_bad++; $display("FAIL hsync_width got %0d expected 192", rises[0] - falls[0]); end
        end
    endtask

    task automatic test_frame();
        int unsigned vfalls[$];
        int unsigned vrises[$];
        int unsigned fs_at[$];
        int unsigned fs_high;
        int max_addr, ea;
        logic prev_vs;
        logic [15:0] act, exp;
        prev_vs = VGA_VS;
        fs_high = 0;
        max_addr = 0;
        while (t < 33700) begin
            @(posedge clock); #1;
            exp = pins_model(t);
            act = {VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_BLANK, frame_start};
            n_cmp++;
            if (act !== exp) begin n_bad++; $display("FAIL frame_pins t=%0d got %h expected %h", t, act, exp); end
            ea = addr_model(t);
            if (ea >= 0) begin
                n_cmp++;
                if (int'(rd_addr) !== ea) begin n_bad++; $display("FAIL frame_rd_addr t=%0d got %0d expected %0d", t, rd_addr, ea); end
            end
            if (int'(rd_addr) > max_addr) max_addr = int'(rd_addr);
            if (prev_vs === 1'b1 && VGA_VS === 1'b0) vfalls.push_back(t);
            if (prev_vs === 1'b0 && VGA_VS === 1'b1) vrises.push_back(t);
            prev_vs = VGA_VS;
            if (frame_start === 1'b1) begin fs_high++; fs_at.push_back(t); end
        end
        n_cmp++;
        if (vfalls.size() != 2 || vrises.size() < 1) begin
            n_bad++; $display("FAIL vsync_edge_count got falls=%0d rises=%0d expected falls=2 rises>=1", vfalls.size(), vrises.size());
        end else begin
            n_cmp++;
            if (vrises[0] - vfalls[0] != 3200) begin n_bad++; $display("FAIL vsync_width got %0d expected 3200", vrises[0] - vfalls[0]); end
            n_cmp++;
            if (vfalls[1] - vfalls[0] != 2 * FRAME) begin n_bad++; $display("FAIL vsync_period got %0d expected %0d", vfalls[1] - vfalls[0], 2 * FRAME); end
        end
        n_cmp++;
        if (fs_high != 2) begin
            n_bad++; $display("FAIL frame_start_pulses got %0d high clocks expected 2", fs_high);
        end else begin
            n_cmp++;
            if (fs_at[1] - fs_at[0] != 2 * FRAME) begin n_bad++; $display("FAIL frame_start_period got %0d expected %0d", fs_at[1] - fs_at[0], 2 * FRAME); end
        end
        n_cmp++;
        if (max_addr != ((VV - 1) / 4) * 160 + 159) begin
            n_bad++; $display("FAIL corner_max_addr got %0d expected %0d", max_addr, ((VV - 1) / 4) * 160 + 159);
        end
    endtask

    task automatic test_pattern();
        int unsigned red_clks, green_clks;
        logic [15:0] act, exp;
        for (int i = 0; i < FB; i++) mem[i] = 3'b000;
        mem[3 * 0 + 160 + 5] = 3'b101;
        do_reset();
        red_clks = 0;
        green_clks = 0;
        repeat (13000) begin
            @(posedge clock); #1;
            exp = pins_model(t);
            act = {VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_BLANK, frame_start};
            n_cmp++;
            if (act !== exp) begin n_bad++; $display("FAIL pattern_pins t=%0d got %h expected %h", t, act, exp); end
            if (VGA_R === 4'hF && VGA_B === 4'hF) red_clks++;
            if (VGA_G !== 4'h0) green_clks++;
        end
        n_cmp++;
        if (red_clks != 32) begin n_bad++; $display("FAIL pattern_block_clocks got %0d expected 32", red_clks); end
        n_cmp++;
        if (green_clks != 0) begin n_bad++; $display("FAIL pattern_green_clocks got %0d expected 0", green_clks); end
    endtask

    task automatic test_blanking();
        logic [15:0] act, exp;
        for (int i = 0; i < FB; i++) mem[i] = 3'b111;
        do_reset();
        repeat (13000) begin
            @(posedge clock); #1;
            exp = pins_model(t);
            act = {VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_BLANK, frame_start};
            n_cmp++;
            if (act !== exp) begin n_bad++; $display("FAIL blank_pins t=%0d got %h expected %h", t, act, exp); end
            n_cmp++;
            if (VGA_BLANK === 1'b0 && {VGA_R, VGA_G, VGA_B} !== 12'h000) begin
                n_bad++; $display("FAIL blank_rgb t=%0d got %h expected 000", t, {VGA_R, VGA_G, VGA_B});
            end else if (VGA_BLANK === 1'b1 && {VGA_R, VGA_G, VGA_B} !== 12'hFFF) begin
                n_bad++; $display("FAIL visible_rgb t=%0d got %h expected fff", t, {VGA_R, VGA_G, VGA_B});
            end
        end
    endtask

    task automatic test_mid_reset();
        int unsigned falls[$];
        int ea;
        logic prev;
        logic [15:0] act, exp;
        for (int i = 0; i < FB; i++) mem[i] = 3'($urandom_range(0, 7));
        do_reset();
        repeat (2 * (5 * HT + 300)) begin
            @(posedge clock); #1;
            exp = pins_model(t);
            act = {VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_BLANK, frame_start};
            n_cmp++;
            if (act !== exp) begin n_bad++; $display("FAIL midrst_pre_pins t=%0d got %h expected %h", t, act, exp); end
            ea = addr_model(t);
            if (ea >= 0) begin
                n_cmp++;
                if (int'(rd_addr) !== ea) begin n_bad++; $display("FAIL midrst_rd_addr t=%0d got %0d expected %0d", t, rd_addr, ea); end
            end
        end
        @(negedge clock); #3;
        reset = 1'b1;
        #1;
        act = {VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_BLANK, frame_start};
        n_cmp++;
        if (act !== RESET_PINS) begin n_bad++; $display("FAIL midrst_async_pins got %h expected %h", act, RESET_PINS); end
        n_cmp++;
        if (rd_addr !== 15'd0) begin n_bad++; $display("FAIL midrst_rd_addr_clear got %0d expected 0", rd_addr); end
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        prev = VGA_HS;
        repeat (3000) begin
            @(posedge clock); #1;
            exp = pins_model(t);
            act = {VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_BLANK, frame_start};
            n_cmp++;
            if (act !== exp) begin n_bad++; $display("FAIL midrst_post_pins t=%0d got %h expected %h", t, act, exp); end
            if (prev === 1'b1 && VGA_HS === 1'b0) falls.push_back(t);
            prev = VGA_HS;
        end
        n_cmp++;
        if (falls.size() != 2) begin
            n_bad++; $display("FAIL midrst_hs_falls got %0d expected 2", falls.size());
        end else begin
            n_cmp++;
            if (falls[0] != 1316) begin n_bad++; $display("FAIL midrst_first_fall got %0d expected 1316", falls[0]); end
            n_cmp++;
            if (falls[1] - falls[0] != 1600) begin n_bad++; $display("FAIL midrst_hs_period got %0d expected 1600", falls[1] - falls[0]); end
        end
    endtask

    initial begin
        for (int i = 0; i < FB; i++) mem[i] = 3'($urandom_range(0, 7));
        test_reset();
        test_hsync();
        test_frame();
        test_pattern();
        test_blanking();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
